// File: rtl/muldiv_seq_if.sv
// Bus between the control unit / AU datapath and the iterative multiply-divide sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath's.
interface muldiv_seq_if;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic        div_by_zero;
    logic        au_own;
    logic [2:0]  au_opcode;
    logic [15:0] au_arg1;
    logic [15:0] au_arg2;
    logic [15:0] au_result;
    logic        au_carry;

    modport slave (
        input  start, op, a, b, au_result, au_carry,
        output busy, done, res_hi, res_lo, div_by_zero,
        output au_own, au_opcode, au_arg1, au_arg2
    );

    modport master (
        output start, op, a, b, au_result, au_carry,
        input  busy, done, res_hi, res_lo, div_by_zero,
        input  au_own, au_opcode, au_arg1, au_arg2
    );
endinterface

// File: rtl/muldiv_seq.sv
// 16x16 unsigned multiply and 16/16 unsigned divide, one bit per cycle through the shared AU.
// r_hi/r_lo hold the partial product (MULU) or remainder/quotient (DIVU).
module muldiv_seq (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] AU_ADD = 3'b000;
    localparam logic [2:0] AU_SUB = 3'b001;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_op;
    logic [15:0] r_b;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [3:0]  r_cnt;
    logic [15:0] r_res_hi;
    logic [15:0] r_res_lo;
    logic        r_dbz;

    logic        w_accept;
    logic        w_dbz_start;
    logic        w_last;
    logic [15:0] w_s;
    logic [15:0] w_hi_next;
    logic [15:0] w_lo_next;

    assign w_accept    = (r_state != S_RUN) && bus.start;
    assign w_dbz_start = w_accept && bus.op && (bus.b == 16'd0);
    assign w_last      = (r_cnt == 4'd15);
    assign w_s         = {r_hi[14:0], r_lo[15]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_dbz_start ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // AU drive and step results depend only on registers, never on start.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.au_own    = 1'b0;
        bus.au_opcode = AU_ADD;
        bus.au_arg1   = 16'd0;
        bus.au_arg2   = 16'd0;
        w_hi_next     = r_hi;
        w_lo_next     = r_lo;
        case (r_state)
            S_RUN: begin
                bus.busy   = 1'b1;
                bus.au_own = 1'b1;
                if (!r_op) begin
                    bus.au_opcode = AU_ADD;
                    bus.au_arg1   = r_hi;
                    bus.au_arg2   = r_lo[0] ? r_b : 16'd0;
                    w_hi_next     = {bus.au_carry, bus.au_result[15:1]};
                    w_lo_next     = {bus.au_result[0], r_lo[15:1]};
                end else begin
                    bus.au_opcode = AU_SUB;
                    bus.au_arg1   = w_s;
                    bus.au_arg2   = r_b;
                    // A set R[15] means the shifted remainder is 17 bits wide, so it always exceeds b.
                    if (r_hi[15] || !bus.au_carry) begin
                        w_hi_next = bus.au_result;
                        w_lo_next = {r_lo[14:0], 1'b1};
                    end else begin
                        w_hi_next = w_s;
                        w_lo_next = {r_lo[14:0], 1'b0};
                    end
                end
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 1'b0;
            r_b      <= 16'd0;
            r_hi     <= 16'd0;
            r_lo     <= 16'd0;
            r_cnt    <= 4'd0;
            r_res_hi <= 16'd0;
            r_res_lo <= 16'd0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_b   <= bus.b;
            r_cnt <= 4'd0;
            r_dbz <= w_dbz_start;
            if (w_dbz_start) begin
                r_res_hi <= bus.a;
                r_res_lo <= 16'hFFFF;
            end else begin
                r_hi <= 16'd0;
                r_lo <= bus.a;
            end
        end else if (r_state == S_RUN) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
                r_res_hi <= w_hi_next;
                r_res_lo <= w_lo_next;
            end
        end
    end

    assign bus.res_hi      = r_res_hi;
    assign bus.res_lo      = r_res_lo;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic-level model checked every cycle, plus directed
// operations with hand-computed results, latency and abort behaviour.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational AU: ADD gives carry-out, SUB gives borrow in bit 16.
    logic [16:0] au_sum;
    always_comb begin
        if (bus.au_opcode == 3'b001) au_sum = {1'b0, bus.au_arg1} - {1'b0, bus.au_arg2};
        else                         au_sum = {1'b0, bus.au_arg1} + {1'b0, bus.au_arg2};
    end
    assign bus.au_result = au_sum[15:0];
    assign bus.au_carry  = au_sum[16];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: results from plain arithmetic, timing as a run-cycle countdown.
    logic        m_run, m_done, m_op, m_dbz;
    int          m_left;
    logic [15:0] m_res_hi, m_res_lo, m_pend_hi, m_pend_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_done <= 1'b0; m_op <= 1'b0; m_dbz <= 1'b0; m_left <= 0;
            m_res_hi <= 16'd0; m_res_lo <= 16'd0; m_pend_hi <= 16'd0; m_pend_lo <= 16'd0;
        end else if (m_run) begin
            if (m_left == 1) begin
                m_run    <= 1'b0;
                m_done   <= 1'b1;
                m_res_hi <= m_pend_hi;
                m_res_lo <= m_pend_lo;
            end
            m_left <= m_left - 1;
        end else if (bus.start) begin
            m_op <= bus.op;
            if (bus.op && bus.b == 16'd0) begin
                m_done   <= 1'b1;
                m_res_hi <= bus.a;
                m_res_lo <= 16'hFFFF;
                m_dbz    <= 1'b1;
            end else begin
                m_run  <= 1'b1;
                m_left <= 16;
                m_done <= 1'b0;
                m_dbz  <= 1'b0;
                if (!bus.op) begin
                    {m_pend_hi, m_pend_lo} <= 32'(bus.a) * 32'(bus.b);
                end else begin
                    m_pend_lo <= bus.a / bus.b;
                    m_pend_hi <= bus.a % bus.b;
                end
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy",   32'(bus.busy),        32'(m_run));
        chk("au_own", 32'(bus.au_own),      32'(m_run));
        chk("done",   32'(bus.done),        32'(m_done));
        chk("dbz",    32'(bus.div_by_zero), 32'(m_dbz));
        if (m_run) begin
            chk("au_opcode", 32'(bus.au_opcode), m_op ? 32'd1 : 32'd0);
        end else begin
            chk("au_opcode_idle", 32'(bus.au_opcode), 32'd0);
            chk("au_arg1_idle",   32'(bus.au_arg1),   32'd0);
            chk("au_arg2_idle",   32'(bus.au_arg2),   32'd0);
        end
        if (m_done) begin
            chk("model_res_hi", 32'(bus.res_hi), 32'(m_res_hi));
            chk("model_res_lo", 32'(bus.res_lo), 32'(m_res_lo));
        end
    end

    // Issues one operation, returns on the negedge where done is seen (still the DONE cycle).
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                          input logic exp_dbz, input int exp_lat, input bit inject,
                          input string tag);
        int lat;
        int busy_n;
        busy_n = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            if (inject && lat == 5) begin
                bus.start = 1'b1; bus.op = ~op; bus.a = 16'h00AA; bus.b = 16'h0003;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        chk({tag, "_res_hi"}, 32'(bus.res_hi), 32'(exp_hi));
        chk({tag, "_res_lo"}, 32'(bus.res_lo), 32'(exp_lo));
        chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        $display("op=%0d a=%04h b=%04h -> hi=%04h lo=%04h dbz=%0d latency=%0d",
                 op, a, b, bus.res_hi, bus.res_lo, bus.div_by_zero, lat);
    endtask

    initial begin
        int saw_done;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = 16'd0; bus.b = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_res_hi", 32'(bus.res_hi), 32'd0);
        chk("reset_res_lo", 32'(bus.res_lo), 32'd0);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 1'b0, "mul_ffff");
        @(negedge clk);
        run_op(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17, 1'b0, "mul_3x5");
        run_op(1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17, 1'b0, "div_100_7_b2b");
        run_op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17, 1'b0, "div_ffff_1");
        run_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 1'b0, "div_m_path");
        @(negedge clk);
        run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1,  1'b0, "div_by_zero");
        @(negedge clk);
        run_op(1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 17, 1'b0, "mul_after_dbz");
        run_op(1'b1, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0101, 1'b0, 17, 1'b0, "div_exact");
        run_op(1'b1, 16'd5,    16'd9,    16'h0005, 16'h0000, 1'b0, 17, 1'b0, "div_small");
        @(negedge clk);
        run_op(1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17, 1'b1, "mul_ignore_start");

        // Abort a multiply mid-run with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'hABCD; bus.b = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",    32'(bus.busy),      32'd0);
        chk("abort_au_own",  32'(bus.au_own),    32'd0);
        chk("abort_done",    32'(bus.done),      32'd0);
        chk("abort_res_hi",  32'(bus.res_hi),    32'd0);
        chk("abort_res_lo",  32'(bus.res_lo),    32'd0);
        chk("abort_au_arg1", 32'(bus.au_arg1),   32'd0);
        chk("abort_opcode",  32'(bus.au_opcode), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) saw_done++;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        run_op(1'b0, 16'hABCD, 16'h1234, 16'h0C37, 16'h4FA4, 1'b0, 17, 1'b0, "mul_after_abort");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
